// File: rtl/alu_issue_ctrl_pkg.sv
// ISA definitions shared by the ALU issue controller: op indices, ALU opcodes,
// PSR flag positions, FSM states and instruction decode helpers.
package alu_isa_pkg;
  localparam int NREG  = 16;
  localparam int IMM_W = 7;

  localparam logic [4:0] K_ADD  = 5'd0,  K_ADDI  = 5'd1,  K_ADDU  = 5'd2,  K_ADDUI = 5'd3,
                         K_ADDC = 5'd4,  K_ADDCU = 5'd5,  K_ADDCUI = 5'd6, K_ADDCI = 5'd7,
                         K_SUB  = 5'd8,  K_SUBI  = 5'd9,  K_CMP   = 5'd10, K_CMPI  = 5'd11,
                         K_AND  = 5'd12, K_OR    = 5'd13, K_XOR   = 5'd14, K_NOT   = 5'd15,
                         K_LSH  = 5'd16, K_LSHI  = 5'd17, K_RSH   = 5'd18, K_RSHI  = 5'd19,
                         K_ALSH = 5'd20, K_ARSH  = 5'd21, K_NOP   = 5'd22;

  localparam logic [7:0] OP_ADD  = {K_ADD, 3'b000},  OP_ADDI  = {K_ADDI, 3'b000},
                         OP_ADDU = {K_ADDU, 3'b000}, OP_ADDUI = {K_ADDUI, 3'b000},
                         OP_ADDC = {K_ADDC, 3'b000}, OP_ADDCU = {K_ADDCU, 3'b000},
                         OP_ADDCUI = {K_ADDCUI, 3'b000}, OP_ADDCI = {K_ADDCI, 3'b000},
                         OP_SUB  = {K_SUB, 3'b000},  OP_SUBI  = {K_SUBI, 3'b000},
                         OP_CMP  = {K_CMP, 3'b000},  OP_CMPI  = {K_CMPI, 3'b000},
                         OP_AND  = {K_AND, 3'b000},  OP_OR    = {K_OR, 3'b000},
                         OP_XOR  = {K_XOR, 3'b000},  OP_NOT   = {K_NOT, 3'b000},
                         OP_LSH  = {K_LSH, 3'b000},  OP_LSHI  = {K_LSHI, 3'b000},
                         OP_RSH  = {K_RSH, 3'b000},  OP_RSHI  = {K_RSHI, 3'b000},
                         OP_ALSH = {K_ALSH, 3'b000}, OP_ARSH  = {K_ARSH, 3'b000},
                         OP_NOP  = {K_NOP, 3'b000};

  localparam int FLAG_Z = 4, FLAG_L = 3, FLAG_F = 2, FLAG_N = 1, FLAG_C = 0;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_EXEC2, S_WB} state_e;

  function automatic logic is_imm(input logic [4:0] k);
    return k inside {K_ADDI, K_ADDUI, K_ADDCUI, K_ADDCI, K_SUBI, K_CMPI, K_LSHI, K_RSHI};
  endfunction

  function automatic logic is_zext(input logic [4:0] k);
    return k inside {K_ADDUI, K_ADDCUI, K_LSHI, K_RSHI};
  endfunction

  function automatic logic is_carry(input logic [4:0] k);
    return k inside {K_ADDC, K_ADDCU, K_ADDCUI, K_ADDCI};
  endfunction

  function automatic logic legal(input logic [4:0] k);
    return k <= K_NOP;
  endfunction

  function automatic logic writes_dest(input logic [4:0] k);
    return legal(k) && !(k inside {K_CMP, K_CMPI, K_NOP});
  endfunction

  function automatic logic writes_psr(input logic [4:0] k);
    return legal(k) && (k != K_NOP);
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus ALU operand/result bus between the issue controller
// and its environment; master is the producer/ALU side, slave is the controller.
interface alu_issue_ctrl_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;

  modport master (output instr, instr_valid, alu_c, alu_flags,
                  input  instr_ready, alu_opcode, alu_a, alu_b);
  modport slave  (input  instr, instr_valid, alu_c, alu_flags,
                  output instr_ready, alu_opcode, alu_a, alu_b);
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// 16x16 register file: one write port, two combinational read ports for operand
// fetch and a third combinational port for debug inspection.
module regfile_16x16
  import alu_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [3:0]  raddr_a_i,
  output logic [15:0] rdata_a_o,
  input  logic [3:0]  raddr_b_i,
  output logic [15:0] rdata_b_o,
  input  logic [3:0]  dbg_addr_i,
  output logic [15:0] dbg_data_o
);
  logic [15:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = mem_q[raddr_a_i];
  assign rdata_b_o  = mem_q[raddr_b_i];
  assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/writeback controller: accepts one instruction, drives the
// external combinational ALU (two passes for carry ops) and writes back C/flags.
module alu_issue_ctrl
  import alu_isa_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic [4:0]      psr,
  output logic            done,
  output logic            illegal,
  input  logic [3:0]      dbg_addr,
  output logic [15:0]     dbg_data
);
  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  opc_q, opc_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] res_q, res_d;
  logic [4:0]  flg_q, flg_d;
  logic [4:0]  psr_q, psr_d;
  logic [15:0] rd_val, rs_val, imm_ext;
  logic [4:0]  k;
  logic        rf_we;

  assign k       = instr_q[15:11];
  assign imm_ext = is_zext(k) ? {{(16-IMM_W){1'b0}}, instr_q[IMM_W-1:0]}
                              : {{(16-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};

  regfile_16x16 u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (instr_q[10:7]),
    .wdata_i    (res_q),
    .raddr_a_i  (instr_q[10:7]),
    .rdata_a_o  (rd_val),
    .raddr_b_i  (instr_q[6:3]),
    .rdata_b_o  (rs_val),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      opc_q   <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      psr_q   <= psr_d;
    end
  end

  // Carry ops run pass 1 as ADD/ADDU, then add the incoming PSR carry with ADDU.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flg_d   = flg_q;
    psr_d   = psr_q;
    rf_we   = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rd_val;
        b_d = is_imm(k) ? imm_ext : rs_val;
        if (is_carry(k)) opc_d = (k == K_ADDC || k == K_ADDCI) ? OP_ADD : OP_ADDU;
        else             opc_d = {k, 3'b000};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = bus.alu_c;
        flg_d = bus.alu_flags;
        if (is_carry(k)) begin
          opc_d   = OP_ADDU;
          a_d     = bus.alu_c;
          b_d     = {15'b0, psr_q[FLAG_L]};
          state_d = S_EXEC2;
        end else begin
          state_d = S_WB;
        end
      end
      S_EXEC2: begin
        res_d         = bus.alu_c;
        flg_d         = bus.alu_flags;
        flg_d[FLAG_L] = flg_q[FLAG_L] | bus.alu_flags[FLAG_L];
        state_d       = S_WB;
      end
      S_WB: begin
        done    = 1'b1;
        illegal = !legal(k);
        rf_we   = writes_dest(k);
        if (writes_psr(k)) psr_d = flg_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.alu_opcode  = opc_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign psr             = psr_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: behavioural ALU plus an instruction-level
// reference model; a monitor checks each completion against queued expectations.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  import alu_isa_pkg::*;

  typedef struct {
    logic        ill;
    logic [3:0]  rd;
    logic [15:0] rdVal;
    logic [4:0]  psr;
    int          doneCyc;
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  psr;
  logic        done;
  logic        illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [3:0]  mainAddr = '0;
  logic [3:0]  monAddr = '0;
  logic        pend = 1'b0;
  logic        skipReady = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        scoreQ[$];
  exp_t        cur;
  logic [7:0]  prevOp = '0;
  logic [15:0] prevA = '0;
  logic [15:0] prevB = '0;
  logic [15:0] mRegs [16];
  logic [4:0]  mPsr = '0;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .psr      (psr),
    .done     (done),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign dbg_addr = pend ? monAddr : mainAddr;

  // Behavioural ALU: returns {flags, result}; flags are {Z, carry/L, F, N, C}.
  function automatic logic [20:0] aluFn(input logic [7:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] c;
    logic [4:0]  f;
    int          kk;
    kk = int'(op[7:3]);
    c  = '0;
    f  = '0;
    case (kk)
      0, 1, 2, 3, 4, 5, 6, 7: begin
        s    = {1'b0, a} + {1'b0, b};
        c    = s[15:0];
        f[3] = s[16];
        f[2] = (a[15] == b[15]) && (c[15] != a[15]);
        f[1] = c[15];
        f[0] = s[16];
      end
      8, 9, 10, 11: begin
        c    = a - b;
        f[3] = a < b;
        f[2] = (a[15] != b[15]) && (c[15] != a[15]);
        f[1] = $signed(a) < $signed(b);
        f[0] = a > b;
      end
      12: c = a & b;
      13: c = a | b;
      14: c = a ^ b;
      15: c = ~a;
      16, 17, 20: c = a << b[3:0];
      18, 19: c = a >> b[3:0];
      21: c = $signed(a) >>> b[3:0];
      default: c = '0;
    endcase
    if (kk <= 21) f[4] = (c == 16'h0000);
    return {f, c};
  endfunction

  always_comb {bus.alu_flags, bus.alu_c} = aluFn(bus.alu_opcode, bus.alu_a, bus.alu_b);

  function automatic logic [15:0] mkR(input int k, input int rd, input int rs);
    logic [4:0] kb;
    logic [3:0] db, sb;
    kb = k[4:0];
    db = rd[3:0];
    sb = rs[3:0];
    return {kb, db, sb, 3'b000};
  endfunction

  function automatic logic [15:0] mkI(input int k, input int rd, input logic [6:0] imm);
    logic [4:0] kb;
    logic [3:0] db;
    kb = k[4:0];
    db = rd[3:0];
    return {kb, db, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Instruction-level reference: operand rules, two-pass carry and writeback exceptions.
  task automatic pushExpected(input logic [15:0] ins, input int acc);
    exp_t        e;
    logic [4:0]  k;
    logic [3:0]  rd, rs;
    logic [6:0]  imm;
    logic [15:0] av, bv, res;
    logic [20:0] r1, r2;
    logic [4:0]  fl;
    k   = ins[15:11];
    rd  = ins[10:7];
    rs  = ins[6:3];
    imm = ins[6:0];
    av  = mRegs[rd];
    if (k inside {1, 3, 6, 7, 9, 11, 17, 19})
      bv = (k inside {3, 6, 17, 19}) ? {9'd0, imm} : {{9{imm[6]}}, imm};
    else
      bv = mRegs[rs];
    if (k inside {[4:7]}) begin
      r1        = aluFn((k == 4 || k == 7) ? OP_ADD : OP_ADDU, av, bv);
      r2        = aluFn(OP_ADDU, r1[15:0], {15'd0, mPsr[3]});
      res       = r2[15:0];
      fl        = r2[20:16];
      fl[3]     = fl[3] | r1[19];
      e.op      = OP_ADDU;
      e.a       = r1[15:0];
      e.b       = {15'd0, mPsr[3]};
      e.doneCyc = acc + 3;
    end else begin
      r1        = aluFn({k, 3'b000}, av, bv);
      res       = r1[15:0];
      fl        = r1[20:16];
      e.op      = {k, 3'b000};
      e.a       = av;
      e.b       = bv;
      e.doneCyc = acc + 2;
    end
    if (k <= 21) begin
      mPsr = fl;
      if (!(k inside {10, 11})) mRegs[rd] = res;
    end
    e.ill   = (k > 22);
    e.rd    = rd;
    e.rdVal = mRegs[rd];
    e.psr   = mPsr;
    scoreQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [15:0] ins, input bit noPush = 1'b0);
    int waitCyc = 0;
    @(negedge clk);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    while (bus.instr_ready !== 1'b1) begin
      waitCyc++;
      if (waitCyc > 50) begin
        checkOutput("acceptTimeout", bus.instr_ready, 1);
        bus.instr_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (!noPush) pushExpected(ins, cyc + 1);
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    while ((scoreQ.size() != 0 || pend) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainQueue", scoreQ.size(), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, bus.instr_ready, 1);
    checkOutput({tag, "_psr"}, psr, 0);
    checkOutput({tag, "_opcode"}, bus.alu_opcode, 8'hB0);
    checkOutput({tag, "_aluA"}, bus.alu_a, 0);
    checkOutput({tag, "_aluB"}, bus.alu_b, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_illegal"}, illegal, 0);
    for (int i = 0; i < 16; i += 5) begin
      mainAddr = i[3:0];
      #1;
      checkOutput({tag, "_reg"}, dbg_data, 0);
    end
  endtask

  // Monitor: pops one expectation per done pulse; psr/register checked the cycle after WB.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        checkOutput("psr", psr, cur.psr);
        checkOutput("regWriteback", dbg_data, cur.rdVal);
        pend = 1'b0;
      end
      if (!skipReady) checkOutput("instrReady", bus.instr_ready, scoreQ.size() == 0);
      if (done === 1'b1) begin
        if (scoreQ.size() == 0) begin
          checkOutput("unexpectedDone", done, 0);
        end else begin
          cur = scoreQ.pop_front();
          checkOutput("doneCycle", cyc, cur.doneCyc);
          checkOutput("illegal", illegal, cur.ill);
          checkOutput("lastOpcode", prevOp, cur.op);
          checkOutput("lastAluA", prevA, cur.a);
          checkOutput("lastAluB", prevB, cur.b);
          monAddr = cur.rd;
          pend    = 1'b1;
        end
      end else begin
        checkOutput("illegalNoDone", illegal, 0);
      end
      prevOp = bus.alu_opcode;
      prevA  = bus.alu_a;
      prevB  = bus.alu_b;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] rk;
    logic [10:0] rbits;
    for (int i = 0; i < 16; i++) mRegs[i] = '0;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    skipReady       = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkResetState("porReset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    skipReady = 1'b0;
    checkResetState("postRelease");

    $display("[TB] directed sequence (valid held high between instructions)");
    applyStimulus(mkI(1, 1, 7'h05));
    applyStimulus(mkR(0, 1, 1));
    applyStimulus(mkI(9, 2, 7'h00));
    applyStimulus(mkI(1, 3, 7'h7F));
    applyStimulus(mkI(3, 3, 7'h01));
    applyStimulus(mkR(5, 5, 0));
    applyStimulus(mkI(1, 6, 7'h7F));
    applyStimulus(mkR(10, 6, 1));
    applyStimulus(mkR(22, 0, 0));
    applyStimulus(mkR(31, 4, 2));
    applyStimulus(mkR(4, 7, 3));
    applyStimulus(mkI(7, 8, 7'h40));
    drain();

    $display("[TB] randomized sequence");
    for (int n = 0; n < 250; n++) begin
      rk    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(23, 31)) : 5'($urandom_range(0, 22));
      rbits = 11'($urandom());
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      applyStimulus({rk, rbits});
    end
    drain();

    $display("[TB] reset during EXEC");
    skipReady = 1'b1;
    applyStimulus(mkI(1, 9, 7'h11), 1'b1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midOpReset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mRegs[i] = '0;
    mPsr = '0;
    @(negedge clk);
    checkResetState("afterAbort");
    skipReady = 1'b0;
    applyStimulus(mkI(1, 9, 7'h03));
    applyStimulus(mkR(10, 9, 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
